// File: rtl/flappy_pkg.sv
// Shared types and defaults for the flappy-bird playfield blocks.
package flappy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      HIT,
      GRACE,
      OVER
   } bird_state_e;

   localparam int DEFAULT_ROWS      = 16;
   localparam int DEFAULT_START_ROW = 8;

   // Bits needed to hold a row index 0..rows-1 (never less than one bit).
   function automatic int row_width(input int rows);
      return (rows < 2) ? 1 : $clog2(rows);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already-synchronised level; one pulse per low-to-high step.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_q <= 1'b0;
      else        sig_q <= sig_i;
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/bird_bounds_tracker.sv
// Owns the bird row: applies flap/gravity moves, detects top/bottom hits and
// sequences lives, respawn grace and game over.
module bird_bounds_tracker
   import flappy_pkg::*;
#(
   parameter int ROWS         = DEFAULT_ROWS,
   parameter int START_ROW    = DEFAULT_START_ROW,
   parameter int FLAP_ROWS    = 1,
   parameter int LIVES        = 3,
   parameter int GRACE_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        key,
   input  logic                        gravity,
   output logic [row_width(ROWS)-1:0]  bird_row,
   output logic [$clog2(LIVES+1)-1:0]  lives_left,
   output logic                        out_of_bounds,
   output logic                        active,
   output logic                        game_over
);

   localparam int RW = row_width(ROWS);
   localparam int LW = $clog2(LIVES + 1);
   localparam int TW = RW + 2;
   localparam int GW = (GRACE_CYCLES < 2) ? 1 : $clog2(GRACE_CYCLES);

   localparam logic        [RW-1:0] START_V    = RW'(START_ROW);
   localparam logic        [LW-1:0] LIVES_V    = LW'(LIVES);
   localparam logic signed [TW-1:0] ONE_V      = TW'(1);
   localparam logic signed [TW-1:0] FLAP_V     = TW'(FLAP_ROWS);
   localparam logic signed [TW-1:0] MAX_V      = TW'(ROWS - 1);
   localparam logic        [GW-1:0] GRACE_LOAD = GW'(GRACE_CYCLES - 1);

   if (ROWS < 2) begin : g_bad_rows
      $error("bird_bounds_tracker: ROWS must be >= 2");
   end
   if (START_ROW < 0 || START_ROW >= ROWS) begin : g_bad_start
      $error("bird_bounds_tracker: START_ROW must be < ROWS");
   end
   if (FLAP_ROWS < 1 || FLAP_ROWS > ROWS - 1) begin : g_bad_flap
      $error("bird_bounds_tracker: FLAP_ROWS must be in 1..ROWS-1");
   end
   if (LIVES < 1) begin : g_bad_lives
      $error("bird_bounds_tracker: LIVES must be >= 1");
   end
   if (GRACE_CYCLES < 0) begin : g_bad_grace
      $error("bird_bounds_tracker: GRACE_CYCLES must be >= 0");
   end

   bird_state_e              state_q, state_d;
   logic        [RW-1:0]     row_q, row_d;
   logic        [LW-1:0]     lives_q, lives_d;
   logic        [GW-1:0]     cnt_q, cnt_d;
   logic signed [TW-1:0]     target;
   logic                     flap;

   edge_detect u_flap_edge (
      .clk    (clk),
      .rst_n  (reset),
      .sig_i  (key),
      .rise_o (flap)
   );

   // Two guard bits keep both the -FLAP_ROWS underflow and the +1 overflow visible.
   always_comb begin
      target = $signed({2'b00, row_q});
      if (gravity) target = target + ONE_V;
      if (flap)    target = target - FLAP_V;
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      lives_d = lives_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            row_d = START_V;
            if (start) state_d = PLAY;
         end
         PLAY: begin
            if (target[TW-1] || (target > MAX_V)) begin
               state_d = HIT;
               lives_d = lives_q - LW'(1);
            end else begin
               row_d = target[RW-1:0];
            end
         end
         HIT: begin
            if (lives_q == '0) begin
               state_d = OVER;
            end else begin
               row_d = START_V;
               if (GRACE_CYCLES == 0) begin
                  state_d = PLAY;
               end else begin
                  state_d = GRACE;
                  cnt_d   = GRACE_LOAD;
               end
            end
         end
         GRACE: begin
            if (cnt_q == '0) state_d = PLAY;
            else             cnt_d   = cnt_q - GW'(1);
         end
         OVER: begin
            if (start) begin
               state_d = PLAY;
               lives_d = LIVES_V;
               row_d   = START_V;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         row_q   <= START_V;
         lives_q <= LIVES_V;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         lives_q <= lives_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bird_row      = row_q;
   assign lives_left    = lives_q;
   assign out_of_bounds = (state_q == HIT);
   assign active        = (state_q == PLAY);
   assign game_over     = (state_q == OVER);

endmodule

// File: tb/tb_bird_bounds_tracker.sv
// Directed bench for bird_bounds_tracker with ROWS=8, START_ROW=4, FLAP_ROWS=2, LIVES=3, GRACE_CYCLES=4.
module tb_bird_bounds_tracker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       key = 1'b0;
   logic       gravity = 1'b0;
   logic [2:0] bird_row;
   logic [1:0] lives_left;
   logic       out_of_bounds;
   logic       active;
   logic       game_over;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bird_bounds_tracker #(
      .ROWS         (8),
      .START_ROW    (4),
      .FLAP_ROWS    (2),
      .LIVES        (3),
      .GRACE_CYCLES (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .key           (key),
      .gravity       (gravity),
      .bird_row      (bird_row),
      .lives_left    (lives_left),
      .out_of_bounds (out_of_bounds),
      .active        (active),
      .game_over     (game_over)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
      n_checks++;
      if (obs !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_state(input string tag, input int row, input int lives,
                               input int oob, input int act, input int go);
      check_val({tag, ".row"},       32'(bird_row),      row);
      check_val({tag, ".lives"},     32'(lives_left),    lives);
      check_val({tag, ".oob"},       32'(out_of_bounds), oob);
      check_val({tag, ".active"},    32'(active),        act);
      check_val({tag, ".game_over"}, 32'(game_over),     go);
   endtask

   // Drive inputs just after an edge; they are sampled at the next edge, then outputs are observed 1 ns later.
   task automatic tick(input logic k, input logic g, input logic s);
      key     = k;
      gravity = g;
      start   = s;
      @(posedge clk);
      #1;
   endtask

   // Called with the HIT cycle just observed: four frozen GRACE cycles, then PLAY.
   task automatic ride_grace(input string tag, input int lives);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         expect_state($sformatf("%s.grace%0d", tag, i), 4, lives, 0, 0, 0);
      end
      tick(1'b0, 1'b0, 1'b0);
      expect_state({tag, ".resume"}, 4, lives, 0, 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset and idle
      repeat (3) @(posedge clk);
      #1;
      expect_state("reset", 4, 3, 0, 0, 0);
      reset = 1'b1;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      expect_state("idle", 4, 3, 0, 0, 0);
      tick(1'b0, 1'b0, 1'b1);
      expect_state("start", 4, 3, 0, 1, 0);

      // 2. bottom hit
      tick(1'b0, 1'b1, 1'b0);
      expect_state("grav1", 5, 3, 0, 1, 0);
      tick(1'b0, 1'b1, 1'b0);
      expect_state("grav2", 6, 3, 0, 1, 0);
      tick(1'b0, 1'b1, 1'b0);
      expect_state("grav3", 7, 3, 0, 1, 0);
      tick(1'b0, 1'b1, 1'b0);
      expect_state("bottom_hit", 7, 2, 1, 0, 0);
      ride_grace("bottom", 2);

      // 3. top hit and edge detection
      tick(1'b1, 1'b0, 1'b0);
      expect_state("flap1", 2, 2, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, 1'b0);
         check_val($sformatf("hold%0d.row", i), 32'(bird_row), 2);
      end
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      expect_state("flap2", 0, 2, 0, 1, 0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      expect_state("top_hit", 0, 1, 1, 0, 0);
      ride_grace("top", 1);

      // 4. simultaneous flap and gravity
      tick(1'b1, 1'b0, 1'b0);
      check_val("to_row2", 32'(bird_row), 2);
      tick(1'b0, 1'b1, 1'b0);
      check_val("to_row3", 32'(bird_row), 3);
      tick(1'b1, 1'b0, 1'b0);
      check_val("to_row1", 32'(bird_row), 1);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      expect_state("simul_ok", 0, 1, 0, 1, 0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      expect_state("simul_hit", 0, 0, 1, 0, 0);

      // 5. game over
      tick(1'b0, 1'b0, 1'b0);
      expect_state("over", 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, 1'b0);
         expect_state($sformatf("over_ign%0d", i), 0, 0, 0, 0, 1);
         tick(1'b0, 1'b1, 1'b0);
      end
      tick(1'b0, 1'b0, 1'b1);
      expect_state("restart", 4, 3, 0, 1, 0);

      // 6. async reset mid-GRACE
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
      expect_state("hit_again", 7, 2, 1, 0, 0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check_val("pre_rst.lives", 32'(lives_left), 2);
      #2;
      reset = 1'b0;
      #1;
      expect_state("async_rst", 4, 3, 0, 0, 0);
      #2;
      reset = 1'b1;
      tick(1'b0, 1'b1, 1'b0);
      expect_state("post_rst_idle", 4, 3, 0, 0, 0);
      tick(1'b1, 1'b0, 1'b0);
      expect_state("post_rst_key", 4, 3, 0, 0, 0);
      tick(1'b0, 1'b0, 1'b1);
      expect_state("post_rst_start", 4, 3, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bird_bounds_tracker.md
Name: bird_bounds_tracker

Overview:
Parametrised successor to the single-bit bounds checker. It owns the bird's vertical row position and applies flap (key rising edge) and gravity-tick moves. It detects top/bottom out-of-bounds and manages a lives / respawn-grace / game-over sequence. It sits between the input conditioning (key, gravity tick generator) and the display/score logic.

Parameters:
ROWS, 16, number of playfield rows; row 0 = top, ROWS-1 = bottom; must be >= 2.
START_ROW, 8, spawn/respawn row; must be < ROWS.
FLAP_ROWS, 1, rows moved up per flap; 1 <= FLAP_ROWS <= ROWS-1.
LIVES, 3, lives per game; must be >= 1.
GRACE_CYCLES, 4, clock cycles the bird is frozen at START_ROW after a non-fatal hit; 0 allowed.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  level; starts a game from IDLE or OVER.
key  input  1  flap button level (already synchronised); flap = rising edge.
gravity  input  1  one-cycle gravity tick.
bird_row  output  $clog2(ROWS)  current bird row.
lives_left  output  $clog2(LIVES+1)  remaining lives.
out_of_bounds  output  1  one-cycle pulse per hit.
active  output  1  high in PLAY only.
game_over  output  1  high in OVER.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-GRACE or mid-HIT) sets state IDLE, bird_row=START_ROW, lives_left=LIVES, key_q=0, and grace counter 0. Reset values of the outputs are out_of_bounds=0, active=0, game_over=0.
- Flap detect: flap = key & ~key_q. key_q is registered every cycle in all states. A key held high yields exactly one flap.
- Net move in PLAY: target = bird_row + (gravity ? 1 : 0) - (flap ? FLAP_ROWS : 0).
  - Computed signed, width $clog2(ROWS)+2.
  - Simultaneous flap and gravity combine; with FLAP_ROWS=1 they cancel.
- States and transitions:
  - IDLE: key and gravity are ignored; bird_row=START_ROW. If start=1, go to PLAY next cycle.
  - PLAY: if target < 0 or target > ROWS-1, go to HIT. bird_row is not updated (it holds its edge row) and lives_left decrements at that edge. Otherwise bird_row <= target. start is ignored.
  - HIT: lasts exactly one cycle with out_of_bounds=1.
    - If lives_left==0, go to OVER.
    - Else if GRACE_CYCLES==0, go to PLAY with bird_row <= START_ROW.
    - Else go to GRACE with bird_row <= START_ROW and counter <= GRACE_CYCLES-1.
  - GRACE: key and gravity are ignored. The counter decrements each cycle; at counter==0, go to PLAY. GRACE lasts exactly GRACE_CYCLES cycles.
  - OVER: game_over=1; bird_row holds its edge row; inputs are ignored. If start=1, go to PLAY next cycle with lives_left <= LIVES and bird_row <= START_ROW.
- All outputs are registered or a state decode (no combinational path from inputs). out_of_bounds rises in the cycle after the edge at which the violation was sampled.
- A violation is never reported twice for one event. Inputs arriving in HIT are dropped.

Decomposition:
- Shared package flappy_pkg holds:
  - typedef enum bird_state_e {IDLE, PLAY, HIT, GRACE, OVER};
  - a row-width helper function;
  - default constants for ROWS/START_ROW used by the display modules.
- One natural sub-module: edge_detect (rising-edge detector with async active-low reset), reusable for other buttons.
- Parameter legality is checked with elaboration-time assertions.

Test Plan:
All scenarios use ROWS=8, START_ROW=4, FLAP_ROWS=2, LIVES=3, GRACE_CYCLES=4.
1. Reset and idle: hold reset=0, release, pulse key and gravity without start -> bird_row=4, lives_left=3, active=0. Assert start -> active=1 on next cycle.
2. Bottom hit: 3 gravity ticks -> bird_row 5,6,7. A 4th tick -> out_of_bounds=1 for one cycle, bird_row=7, lives_left=2. Then bird_row=4 and active=0 for 4 cycles, then active=1.
3. Top hit and edge detection: from row 4, hold key high 5 cycles -> one flap only, bird_row=2. Second edge -> 0. Third edge -> out_of_bounds pulse, lives_left decremented.
4. Simultaneous: at row 1, flap+gravity same cycle -> bird_row=0, no hit. At row 0, flap+gravity -> target -1 -> hit.
5. Game over: three hits -> lives_left=0, game_over=1; key and gravity ignored, no further pulses. start -> lives_left=3, bird_row=4, active=1.
6. Async reset mid-GRACE: drive reset=0 between clock edges -> outputs take reset values before the next edge; state is IDLE after release.
